// File: rtl/grt_sched_if.sv
// Requester-side bundle for grt_sched: ports C and D, copy engine, hold.
// master = requesters (drive req/dst/data/dir/hold), slave = scheduler.
interface grt_sched_if #(
  parameter int W = 4
);
  logic         c_req;
  logic [1:0]   c_dst;
  logic [W-1:0] c_data;
  logic         c_ack;
  logic         d_req;
  logic [1:0]   d_dst;
  logic [W-1:0] d_data;
  logic         d_ack;
  logic         x_req;
  logic         x_dir;
  logic         x_ack;
  logic         hold;

  modport master (
    output c_req, c_dst, c_data,
    output d_req, d_dst, d_data,
    output x_req, x_dir, hold,
    input  c_ack, d_ack, x_ack
  );

  modport slave (
    input  c_req, c_dst, c_data,
    input  d_req, d_dst, d_data,
    input  x_req, x_dir, hold,
    output c_ack, d_ack, x_ack
  );
endinterface

// File: rtl/grt_sched.sv
// Round-robin transfer scheduler owning registers A and B (C, D, copy).
// Ports: clk, rst_n, bus (requesters), o_a_reg/o_b_reg, gates, sel, busy, cnt.
module grt_sched #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  grt_sched_if.slave       bus,
  output logic [W-1:0]     o_a_reg,
  output logic [W-1:0]     o_b_reg,
  output logic             o_g_a,
  output logic             o_g_b,
  output logic [1:0]       o_bus_sel,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_xfer_cnt
);

  typedef enum logic {
    S_IDLE,
    S_XFER
  } state_t;

  // pointer holds the last granted requester
  localparam logic [1:0] P_C = 2'd0;
  localparam logic [1:0] P_D = 2'd1;
  localparam logic [1:0] P_X = 2'd2;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_ptr;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_bus_q;
  logic [1:0]       r_dst_q;
  logic [1:0]       r_sel;
  logic [2:0]       r_ack;
  logic             r_g_a;
  logic             r_g_b;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]       w_req;
  logic [2:0]       w_gnt;
  logic             w_grant;
  logic [W-1:0]     w_data;
  logic [1:0]       w_dst;
  logic [1:0]       w_sel;
  logic [1:0]       w_ptr;

  assign w_req = {bus.x_req, bus.d_req, bus.c_req};

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.hold && (|w_req)) begin
          w_grant     = 1'b1;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: w_state_nxt = S_IDLE;
    endcase
  end

  // search starts just after the last winner
  always_comb begin
    w_gnt = 3'b000;
    unique case (r_ptr)
      P_C: begin
        if      (w_req[1]) w_gnt = 3'b010;
        else if (w_req[2]) w_gnt = 3'b100;
        else if (w_req[0]) w_gnt = 3'b001;
      end
      P_D: begin
        if      (w_req[2]) w_gnt = 3'b100;
        else if (w_req[0]) w_gnt = 3'b001;
        else if (w_req[1]) w_gnt = 3'b010;
      end
      default: begin
        if      (w_req[0]) w_gnt = 3'b001;
        else if (w_req[1]) w_gnt = 3'b010;
        else if (w_req[2]) w_gnt = 3'b100;
      end
    endcase
  end

  always_comb begin
    w_data = '0;
    w_dst  = 2'b00;
    w_sel  = 2'b00;
    w_ptr  = r_ptr;
    unique case (1'b1)
      w_gnt[0]: begin
        w_data = bus.c_data;
        w_dst  = bus.c_dst;
        w_sel  = 2'b01;
        w_ptr  = P_C;
      end
      w_gnt[1]: begin
        w_data = bus.d_data;
        w_dst  = bus.d_dst;
        w_sel  = 2'b10;
        w_ptr  = P_D;
      end
      w_gnt[2]: begin
        // copy: source is the opposite register
        w_data = bus.x_dir ? r_b : r_a;
        w_dst  = bus.x_dir ? 2'b01 : 2'b10;
        w_sel  = 2'b11;
        w_ptr  = P_X;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= P_X;
      r_a     <= '0;
      r_b     <= '0;
      r_bus_q <= '0;
      r_dst_q <= 2'b00;
      r_sel   <= 2'b00;
      r_ack   <= 3'b000;
      r_g_a   <= 1'b0;
      r_g_b   <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_bus_q <= w_data;
        r_dst_q <= w_dst;
        r_sel   <= w_sel;
        r_ptr   <= w_ptr;
        r_ack   <= w_gnt;
        r_g_a   <= w_dst[0];
        r_g_b   <= w_dst[1];
        r_busy  <= 1'b1;
      end else if (r_state == S_XFER) begin
        if (r_dst_q[0]) r_a <= r_bus_q;
        if (r_dst_q[1]) r_b <= r_bus_q;
        if (|r_dst_q)   r_cnt <= r_cnt + 1'b1;
        r_sel  <= 2'b00;
        r_ack  <= 3'b000;
        r_g_a  <= 1'b0;
        r_g_b  <= 1'b0;
        r_busy <= 1'b0;
      end
    end
  end

  assign bus.c_ack  = r_ack[0];
  assign bus.d_ack  = r_ack[1];
  assign bus.x_ack  = r_ack[2];
  assign o_a_reg    = r_a;
  assign o_b_reg    = r_b;
  assign o_g_a      = r_g_a;
  assign o_g_b      = r_g_b;
  assign o_bus_sel  = r_sel;
  assign o_busy     = r_busy;
  assign o_xfer_cnt = r_cnt;

endmodule

// File: tb/tb_grt_sched.sv
// Scoreboard bench for grt_sched: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_grt_sched;
  localparam int W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  grt_sched_if #(.W(W)) ifc ();

  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             g_a;
  logic             g_b;
  logic [1:0]       bus_sel;
  logic             busy;
  logic [CNT_W-1:0] xfer_cnt;

  logic [2:0]   t_req = '0;
  logic [1:0]   t_dst [2];
  logic [W-1:0] t_data [2];
  logic         t_dir = 1'b0;
  logic         t_hold = 1'b0;

  assign ifc.c_req  = t_req[0];
  assign ifc.c_dst  = t_dst[0];
  assign ifc.c_data = t_data[0];
  assign ifc.d_req  = t_req[1];
  assign ifc.d_dst  = t_dst[1];
  assign ifc.d_data = t_data[1];
  assign ifc.x_req  = t_req[2];
  assign ifc.x_dir  = t_dir;
  assign ifc.hold   = t_hold;

  grt_sched #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifc),
    .o_a_reg    (a_reg),
    .o_b_reg    (b_reg),
    .o_g_a      (g_a),
    .o_g_b      (g_b),
    .o_bus_sel  (bus_sel),
    .o_busy     (busy),
    .o_xfer_cnt (xfer_cnt)
  );

  typedef struct {
    int           who;
    logic [1:0]   dst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           cnt;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] acks();
    return {ifc.x_ack, ifc.d_ack, ifc.c_ack};
  endfunction

  // Reference model: one grant per idle edge, transfer takes one more edge.
  int           m_last;
  int           m_cnt;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  bit           m_busy;
  exp_t         m_pend;

  initial begin
    m_last = 2; m_cnt = 0; m_a = '0; m_b = '0; m_busy = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_last = 2; m_cnt = 0; m_a = '0; m_b = '0; m_busy = 0;
        sb.delete();
      end else if (m_busy) begin
        m_a = m_pend.a;
        m_b = m_pend.b;
        m_cnt = m_pend.cnt;
        m_busy = 0;
      end else if (!t_hold && t_req != 0) begin
        int idx;
        logic [W-1:0] v;
        exp_t e;
        idx = -1;
        for (int k = 1; k <= 3; k++)
          if (idx < 0 && t_req[(m_last + k) % 3]) idx = (m_last + k) % 3;
        if (idx == 2) begin
          e.dst = t_dir ? 2'b01 : 2'b10;
          v = t_dir ? m_b : m_a;
        end else begin
          e.dst = t_dst[idx];
          v = t_data[idx];
        end
        e.who = idx;
        e.a = e.dst[0] ? v : m_a;
        e.b = e.dst[1] ? v : m_b;
        e.cnt = (m_cnt + (e.dst != 0 ? 1 : 0)) % (1 << CNT_W);
        sb.push_back(e);
        m_pend = e;
        m_last = idx;
        m_busy = 1;
      end
    end
  end

  // Monitor: every acked XFER cycle is popped and checked.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (acks() != 0) begin
          if (sb.size() == 0) begin
            chk("unexpected_ack", {29'd0, acks()}, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ack", {29'd0, acks()}, 32'(3'b001 << e.who));
            chk("g_a", {31'd0, g_a}, {31'd0, e.dst[0]});
            chk("g_b", {31'd0, g_b}, {31'd0, e.dst[1]});
            chk("bus_sel", {30'd0, bus_sel}, 32'(e.who + 1));
            chk("busy", {31'd0, busy}, 1);
            @(posedge clk);
            #1;
            chk("a_reg", {28'd0, a_reg}, {28'd0, e.a});
            chk("b_reg", {28'd0, b_reg}, {28'd0, e.b});
            chk("xfer_cnt", {24'd0, xfer_cnt}, 32'(e.cnt));
          end
        end else begin
          chk("idle_outs", {27'd0, busy, g_a, g_b, bus_sel}, 0);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    t_req = '0;
    t_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int p, input int budget, input bit hold_on,
                          output int lat);
    lat = -1;
    for (int i = 1; i <= budget && lat < 0; i++) begin
      @(negedge clk);
      if (acks()[p]) begin
        lat = i;
        t_req[p] = 1'b0;
        if (hold_on) t_hold = 1'b1;
      end
    end
    if (lat < 0) begin
      chk("ack_timeout", 32'(p), 32'hFFFF);
      t_req[p] = 1'b0;
    end
  endtask

  int got_who[$];
  int got_t[$];

  task automatic serve(input int budget);
    got_who.delete();
    got_t.delete();
    for (int i = 1; i <= budget && t_req != 0; i++) begin
      @(negedge clk);
      for (int p = 0; p < 3; p++)
        if (acks()[p]) begin
          got_who.push_back(p);
          got_t.push_back(i);
          t_req[p] = 1'b0;
        end
    end
    if (t_req != 0) begin
      chk("serve_timeout", {29'd0, t_req}, 0);
      t_req = '0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int nack;
    t_dst[0] = 2'b00; t_dst[1] = 2'b00;
    t_data[0] = '0;   t_data[1] = '0;

    // basic transfer out of reset
    do_reset();
    @(negedge clk);
    chk("rst_a", {28'd0, a_reg}, 0);
    chk("rst_b", {28'd0, b_reg}, 0);
    chk("rst_cnt", {24'd0, xfer_cnt}, 0);
    chk("rst_ctl", {26'd0, acks(), busy, bus_sel != 0}, 0);
    t_dst[0] = 2'b01; t_data[0] = 4'hA; t_req[0] = 1'b1;
    wait_ack(0, 4, 0, lat);
    chk("t1_latency", 32'(lat), 1);
    @(negedge clk);
    chk("t1_a", {28'd0, a_reg}, 32'hA);
    chk("t1_cnt", {24'd0, xfer_cnt}, 1);

    // three-way contention
    do_reset();
    t_dst[0] = 2'b10; t_data[0] = 4'h3;
    t_dst[1] = 2'b01; t_data[1] = 4'h5;
    t_dir = 1'b0;
    t_req = 3'b111;
    serve(12);
    chk("t2_n", 32'(got_who.size()), 3);
    if (got_who.size() == 3)
      for (int k = 0; k < 3; k++) begin
        chk("t2_order", 32'(got_who[k]), 32'(k));
        chk("t2_when", 32'(got_t[k]), 32'(2 * k + 1));
      end
    @(negedge clk);
    chk("t2_a", {28'd0, a_reg}, 5);
    chk("t2_b", {28'd0, b_reg}, 5);
    chk("t2_cnt", {24'd0, xfer_cnt}, 3);

    // broadcast then null destination
    t_dst[1] = 2'b11; t_data[1] = 4'hF; t_req[1] = 1'b1;
    wait_ack(1, 6, 0, lat);
    @(negedge clk);
    chk("t3_a", {28'd0, a_reg}, 32'hF);
    chk("t3_b", {28'd0, b_reg}, 32'hF);
    t_dst[1] = 2'b00; t_data[1] = 4'h7; t_req[1] = 1'b1;
    wait_ack(1, 6, 0, lat);
    chk("t3_null_ack", 32'(lat > 0), 1);
    @(negedge clk);
    chk("t3_null_a", {28'd0, a_reg}, 32'hF);
    chk("t3_null_b", {28'd0, b_reg}, 32'hF);
    chk("t3_null_cnt", {24'd0, xfer_cnt}, 4);

    // hold blocks grants, but not a transfer in flight
    t_hold = 1'b1;
    t_dst[0] = 2'b01; t_data[0] = 4'h6; t_req[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_ack", {31'd0, ifc.c_ack}, 0);
      chk("t4_hold_busy", {31'd0, busy}, 0);
    end
    t_hold = 1'b0;
    wait_ack(0, 4, 0, lat);
    chk("t4_release_lat", 32'(lat), 1);
    @(negedge clk);
    t_dst[0] = 2'b10; t_data[0] = 4'h9; t_req[0] = 1'b1;
    wait_ack(0, 6, 1, lat);
    @(negedge clk);
    chk("t4_inflight_b", {28'd0, b_reg}, 32'h9);
    t_hold = 1'b0;

    // reset in the middle of XFER
    @(negedge clk);
    t_dst[0] = 2'b01; t_data[0] = 4'h3; t_req[0] = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    t_req = '0;
    #1;
    chk("t5_a", {28'd0, a_reg}, 0);
    chk("t5_b", {28'd0, b_reg}, 0);
    chk("t5_cnt", {24'd0, xfer_cnt}, 0);
    chk("t5_ack", {29'd0, acks()}, 0);
    @(negedge clk);
    chk("t5_ack_low", {29'd0, acks()}, 0);
    rst_n = 1'b1;
    t_dst[1] = 2'b10; t_data[1] = 4'h2; t_dir = 1'b1;
    t_req = 3'b111;
    serve(12);
    if (got_who.size() > 0)
      chk("t5_first_c", 32'(got_who[0]), 0);
    else
      chk("t5_no_grant", 0, 1);

    // counter wrap at back-to-back rate
    do_reset();
    t_dst[0] = 2'b01; t_data[0] = 4'(($urandom)); t_req[0] = 1'b1;
    nack = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (ifc.c_ack) begin
        nack++;
        t_data[0] = 4'($urandom);
      end
    end
    t_req[0] = 1'b0;
    chk("t6_acks", 32'(nack), 256);
    chk("t6_wrap", {24'd0, xfer_cnt}, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      t_hold = ($urandom % 5) == 0;
      for (int p = 0; p < 3; p++) begin
        if (t_req[p] && acks()[p]) begin
          t_req[p] = 1'b0;
        end else if (!t_req[p] && ($urandom % 3) == 0) begin
          if (p < 2) begin
            t_dst[p] = 2'($urandom);
            t_data[p] = 4'($urandom);
          end else begin
            t_dir = 1'($urandom);
          end
          t_req[p] = 1'b1;
        end
      end
    end
    t_hold = 1'b0;
    serve(30);
    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
